ads8528_read_ctrl: RTL and testbench
====================================

// Module: ads8528_read_ctrl
// PURPOSE
//  Synthesizable host-side controller for the ADS8528 8-ch parallel ADC.
//  - Writes the 32-bit config register as two 16-bit WR_N strobes.
//  - Fires all four CONVST_x together and waits on BUSY.
//  - Reads the 8 results (A0,A1,B0,B1,C0,C1,D0,D1) via RD_N and streams them as tagged samples.
//  - Sits between the ADC pins (DB tri-state resolved at top level) and the sound-localization sample pipeline.
// PARAMETERS
//  CONFIG_WORD   32'h0000_03FF  config value; [31:16] written first; bit29 CLKSEL=0 (internal conv clock)
//  T_SETUP       1              cycles CS_N/DB valid before WR_N or RD_N falls
//  T_WRL         2              WR_N low cycles
//  T_RDL         2              RD_N low cycles; DB sampled on last low cycle
//  T_HIGH        2              WR_N/RD_N high cycles between strobes
//  T_CNVH        2              CONVST high cycles
//  BUSY_TIMEOUT  200            max cycles from CONVST rise to synced BUSY fall
// PORTS
//  CLK          in   1   system clock (50 MHz nominal), only clock
//  RST_N        in   1   synchronous active-low reset
//  cfg_req      in   1   pulse: run config write sequence
//  conv_req     in   1   pulse: run one conversion + 8-word readout
//  BUSY         in   1   ADC busy, asynchronous; 2-flop synchronized internally
//  DB_IN        in   16  databus input
//  DB_OUT       out  16  databus drive value
//  DB_OE        out  1   1 = host drives DB
//  CS_N         out  1   chip select
//  WR_N         out  1   write strobe
//  RD_N         out  1   read strobe
//  CONVST       out  4   {D,C,B,A} convert start, always driven identically
//  sample_valid out  1   one-cycle pulse per read word
//  sample_data  out  16  read word, held until next sample_valid
//  sample_idx   out  3   0..7 = A0,A1,B0,B1,C0,C1,D0,D1
//  frame_done   out  1   pulse with the idx-7 sample_valid
//  cfg_done     out  1   pulse when config sequence completes
//  ctrl_busy    out  1   high whenever FSM is not IDLE
//  timeout_err  out  1   pulse when BUSY timeout fires
// BEHAVIOUR
//  Clocking/reset: one clock, synchronous active-low reset (RST_N).
//  Reset values (next edge with RST_N=0):
//    CS_N=WR_N=RD_N=1; CONVST=0; DB_OE=0; DB_OUT=0
//    all pulses=0; sample_data=0; sample_idx=0; ctrl_busy=0; FSM=IDLE
//  Reset mid-operation aborts immediately; no partial frame or cfg_done emitted.
//  FSM: IDLE -> CFG_SETUP -> CFG_WRL -> CFG_WRH (x2 words) -> IDLE
//       IDLE -> CNV_HI -> WAIT_BUSY -> RD_SETUP -> RD_L -> RD_H (x8) -> IDLE
//  IDLE: cfg_req wins if cfg_req and conv_req arrive in the same cycle; the loser is dropped.
//        Requests arriving while not IDLE are ignored (no queueing).
//  Config:
//    - CS_N=0, DB_OE=1, DB_OUT=CONFIG_WORD[31:16] for T_SETUP cycles, then WR_N=0 for T_WRL, WR_N=1 for T_HIGH.
//    - Repeat with [15:0].
//    - DB is stable from T_SETUP before WR_N falls until WR_N rises; the ADC latches on WR_N fall.
//    - After 2nd T_HIGH: CS_N=1, DB_OE=0, cfg_done pulse, IDLE.
//  Conversion:
//    - CONVST=4'hF for T_CNVH cycles starting the cycle after conv_req, then 0.
//    - WAIT_BUSY requires the synced BUSY to be seen high and then low.
//    - Timeout counter starts at CONVST rise. At count BUSY_TIMEOUT: timeout_err pulse, CS_N=1, IDLE, no samples.
//  Readout:
//    - CS_N=0 for the whole 8-word frame; DB_OE=0 throughout.
//    - Each word: RD_N=0 for T_RDL cycles; DB_IN is registered on the last low cycle.
//    - sample_valid pulses the cycle RD_N returns high, with sample_idx = word count 0..7; the 3-bit counter wraps to 0 after 7.
//    - RD_N=1 for T_HIGH between words. After word 7: frame_done, CS_N=1, IDLE.
//  Invariants:
//    - WR_N and RD_N are never both 0.
//    - DB_OE=0 whenever RD_N=0.
//    - CONVST is never high during a readout or config.
// TESTING (bench uses the ADS8528 behavioural model, CLKSEL=0)
//  1 Reset: hold RST_N=0 for 3 cycles -> CS_N=WR_N=RD_N=1, CONVST=0, DB_OE=0, ctrl_busy=0.
//  2 cfg_req pulse -> two WR_N lows; model CONFIG_REG==32'h0000_03FF; cfg_done one pulse; DB_OE=0 afterwards.
//  3 conv_req after config -> CONVST=F for 2 cycles; 8 sample_valid, idx 0..7.
//    Each data word equals model CH_A0..CH_D1; frame_done coincides with idx 7.
//  4 Bench holds BUSY low (forced) after conv_req -> timeout_err at cycle 200, no sample_valid, back to IDLE.
//  5 cfg_req and conv_req in the same cycle, then conv_req again mid-config -> only config runs; 0 samples.
//  6 RST_N low during read word 3 -> next cycle CS_N=RD_N=1.
//    Fresh conv_req then yields a full frame starting at idx 0.

Source files
------------

// File: rtl/ads8528_read_ctrl.sv
// Host-side sequencer for the ADS8528 8-channel parallel ADC.
// Writes the 32-bit config register as two 16-bit WR_N strobes.
// Fires all four CONVST lines together and waits for BUSY to rise and fall.
// Reads the eight results with RD_N and streams them out as indexed samples.
module ads8528_read_ctrl #(
    parameter logic [31:0] CONFIG_WORD  = 32'h0000_03FF,
    parameter int          T_SETUP      = 1,
    parameter int          T_WRL        = 2,
    parameter int          T_RDL        = 2,
    parameter int          T_HIGH       = 2,
    parameter int          T_CNVH       = 2,
    parameter int          BUSY_TIMEOUT = 200
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cfg_req,
    input  logic        conv_req,
    input  logic        BUSY,
    input  logic [15:0] DB_IN,
    output logic [15:0] DB_OUT,
    output logic        DB_OE,
    output logic        CS_N,
    output logic        WR_N,
    output logic        RD_N,
    output logic [3:0]  CONVST,
    output logic        sample_valid,
    output logic [15:0] sample_data,
    output logic [2:0]  sample_idx,
    output logic        frame_done,
    output logic        cfg_done,
    output logic        ctrl_busy,
    output logic        timeout_err
);

    localparam int CW = 8;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LAST_WRL   = CW'(T_WRL - 1);
    localparam logic [CW-1:0] LAST_RDL   = CW'(T_RDL - 1);
    localparam logic [CW-1:0] LAST_HIGH  = CW'(T_HIGH - 1);
    localparam logic [CW-1:0] LAST_CNVH  = CW'(T_CNVH - 1);
    localparam logic [TW-1:0] LAST_WAIT  = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CFG_SETUP = 4'd1,
        CFG_WRL   = 4'd2,
        CFG_WRH   = 4'd3,
        CNV_HI    = 4'd4,
        WAIT_BUSY = 4'd5,
        RD_SETUP  = 4'd6,
        RD_L      = 4'd7,
        RD_H      = 4'd8
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;        // cycles spent in the current phase
    logic [2:0]    word_cnt;   // config half (bit 0) or read word index
    logic [TW-1:0] tcnt;       // cycles since CONVST rose
    logic          busy_s1, busy_s2;
    logic          busy_seen;
    logic          phase_last;
    logic          busy_done;
    logic          to_hit;
    logic          rd_last;

    // Two-flop synchronizer for the asynchronous BUSY pin
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy_s1 <= 1'b0;
            busy_s2 <= 1'b0;
        end else begin
            busy_s1 <= BUSY;
            busy_s2 <= busy_s1;
        end
    end

    // Decode whether this is the final cycle of the current timed phase
    always_comb begin
        phase_last = 1'b0;
        case (state)
            CFG_SETUP, RD_SETUP: phase_last = (cnt == LAST_SETUP);
            CFG_WRL:             phase_last = (cnt == LAST_WRL);
            CFG_WRH, RD_H:       phase_last = (cnt == LAST_HIGH);
            CNV_HI:              phase_last = (cnt == LAST_CNVH);
            RD_L:                phase_last = (cnt == LAST_RDL);
            default:             phase_last = 1'b0;
        endcase
    end

    // A completed conversion beats a timeout landing on the same cycle
    assign busy_done = (state == WAIT_BUSY) && busy_seen && !busy_s2;
    assign to_hit    = (state == WAIT_BUSY) && !busy_done && (tcnt == LAST_WAIT);
    assign rd_last   = (state == RD_L) && phase_last;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; requests outside IDLE are dropped, cfg_req has priority
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_req)       state_nxt = CFG_SETUP;
                else if (conv_req) state_nxt = CNV_HI;
            end
            CFG_SETUP: if (phase_last) state_nxt = CFG_WRL;
            CFG_WRL:   if (phase_last) state_nxt = CFG_WRH;
            CFG_WRH:   if (phase_last) state_nxt = word_cnt[0] ? IDLE : CFG_SETUP;
            CNV_HI:    if (phase_last) state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy_done)   state_nxt = RD_SETUP;
                else if (to_hit) state_nxt = IDLE;
            end
            RD_SETUP:  if (phase_last) state_nxt = RD_L;
            RD_L:      if (phase_last) state_nxt = RD_H;
            RD_H:      if (phase_last) state_nxt = (word_cnt == 3'd7) ? IDLE : RD_L;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        CS_N      = 1'b1;
        WR_N      = 1'b1;
        RD_N      = 1'b1;
        CONVST    = 4'h0;
        DB_OE     = 1'b0;
        DB_OUT    = 16'h0000;
        ctrl_busy = (state != IDLE);
        case (state)
            CFG_SETUP, CFG_WRL, CFG_WRH: begin
                CS_N   = 1'b0;
                DB_OE  = 1'b1;
                DB_OUT = word_cnt[0] ? CONFIG_WORD[15:0] : CONFIG_WORD[31:16];
                WR_N   = (state != CFG_WRL);
            end
            CNV_HI:         CONVST = 4'hF;
            RD_SETUP, RD_H: CS_N   = 1'b0;
            RD_L: begin
                CS_N = 1'b0;
                RD_N = 1'b0;
            end
            default: ;
        endcase
    end

    // Phase, word and timeout counters plus the BUSY-high latch
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt       <= '0;
            word_cnt  <= '0;
            tcnt      <= '0;
            busy_seen <= 1'b0;
        end else begin
            cnt <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;

            if (state == IDLE)
                word_cnt <= '0;
            else if ((state == CFG_WRH || state == RD_H) && phase_last)
                word_cnt <= word_cnt + 1'b1;

            if (state == IDLE)
                tcnt <= '0;
            else if (state == CNV_HI || state == WAIT_BUSY)
                tcnt <= tcnt + 1'b1;

            if (state == IDLE)
                busy_seen <= 1'b0;
            else if ((state == CNV_HI || state == WAIT_BUSY) && busy_s2)
                busy_seen <= 1'b1;
        end
    end

    // Sample capture and one-cycle status pulses
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sample_valid <= 1'b0;
            sample_data  <= 16'h0000;
            sample_idx   <= 3'd0;
            frame_done   <= 1'b0;
            cfg_done     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            sample_valid <= rd_last;
            frame_done   <= rd_last && (word_cnt == 3'd7);
            cfg_done     <= (state == CFG_WRH) && phase_last && word_cnt[0];
            timeout_err  <= to_hit;
            if (rd_last) begin
                sample_data <= DB_IN;
                sample_idx  <= word_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ads8528_read_ctrl.sv
// Self-checking bench for ads8528_read_ctrl with a small ADS8528 model.
`timescale 1ns/1ps
module tb_ads8528_read_ctrl;

    localparam logic [31:0] CFG_EXP  = 32'h0000_03FF;
    localparam int          TO_CYC   = 200;
    localparam int          CFG_CYC  = 2 * (1 + 2 + 2);

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cfg_req = 1'b0;
    logic        conv_req = 1'b0;
    logic        BUSY;
    logic [15:0] DB_IN;
    logic [15:0] DB_OUT;
    logic        DB_OE, CS_N, WR_N, RD_N;
    logic [3:0]  CONVST;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [2:0]  sample_idx;
    logic        frame_done, cfg_done, ctrl_busy, timeout_err;

    int n_pass = 0;
    int n_total = 0;

    always #10 CLK = ~CLK;

    ads8528_read_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .cfg_req(cfg_req), .conv_req(conv_req),
        .BUSY(BUSY), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N), .CONVST(CONVST),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_idx(sample_idx), .frame_done(frame_done), .cfg_done(cfg_done),
        .ctrl_busy(ctrl_busy), .timeout_err(timeout_err)
    );

    // ---------------- ADS8528 behavioural model ----------------
    logic [15:0] ch [8];
    logic [15:0] db_word = 16'h0000;
    logic [31:0] cfg_reg = 32'h0;
    logic        busy_m = 1'b0;
    logic        force_low = 1'b0;
    int          rd_ptr = 0;
    int          wr_falls = 0;
    int          rd_falls = 0;

    assign BUSY  = busy_m & ~force_low;
    assign DB_IN = (CS_N === 1'b0 && RD_N === 1'b0) ? db_word : 16'hDEAD;

    // New random conversion results on every CONVST rise; BUSY for 20..60 cycles
    always @(posedge CONVST[0]) begin
        for (int i = 0; i < 8; i++) ch[i] = 16'($urandom);
        rd_ptr = 0;
        @(posedge CLK); #3 busy_m = 1'b1;
        repeat ($urandom_range(60, 20)) @(posedge CLK);
        #3 busy_m = 1'b0;
    end

    // ADC presents the next channel on each RD_N fall
    always @(negedge RD_N) begin
        if (CS_N === 1'b0) begin
            db_word = (rd_ptr < 8) ? ch[rd_ptr] : 16'hBEEF;
            rd_ptr++;
            rd_falls++;
        end
    end

    // Config register latches on WR_N fall, upper half first
    always @(negedge WR_N) begin
        if (CS_N === 1'b0 && DB_OE === 1'b1) begin
            cfg_reg = {cfg_reg[15:0], DB_OUT};
            wr_falls++;
        end
    end

    // ---------------- output monitor ----------------
    logic [2:0]  sq_idx [$];
    logic [15:0] sq_dat [$];
    int fd_cnt = 0, fd_bad = 0, cd_cnt = 0, to_cnt = 0;
    int cv_cyc = 0, busy_cyc = 0, inv_bad = 0;

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (sample_valid === 1'b1) begin
                sq_idx.push_back(sample_idx);
                sq_dat.push_back(sample_data);
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (frame_done !== (sample_valid === 1'b1 && sample_idx === 3'd7)) fd_bad++;
            if (cfg_done === 1'b1) cd_cnt++;
            if (timeout_err === 1'b1) to_cnt++;
            if (CONVST === 4'hF) cv_cyc++;
            if (ctrl_busy === 1'b1) busy_cyc++;
            if (WR_N === 1'b0 && RD_N === 1'b0) inv_bad++;
            if (RD_N === 1'b0 && DB_OE !== 1'b0) inv_bad++;
            if (CONVST !== 4'h0 && CS_N === 1'b0) inv_bad++;
            if (CONVST !== 4'h0 && CONVST !== 4'hF) inv_bad++;
        end
    end

    task automatic clear_mon();
        sq_idx.delete(); sq_dat.delete();
        fd_cnt = 0; fd_bad = 0; cd_cnt = 0; to_cnt = 0;
        cv_cyc = 0; busy_cyc = 0; wr_falls = 0; rd_falls = 0;
    endtask

    task automatic pulse(input logic c, input logic v);
        @(negedge CLK); cfg_req = c; conv_req = v;
        @(negedge CLK); cfg_req = 1'b0; conv_req = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (ctrl_busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_total++;
        if ({CS_N, WR_N, RD_N} !== 3'b111) $display("FAIL reset_strobes: got %b want 111", {CS_N, WR_N, RD_N});
        else n_pass++;
        n_total++;
        if ({CONVST, DB_OE, ctrl_busy} !== 6'b0) $display("FAIL reset_convst_oe_busy: got %b want 000000", {CONVST, DB_OE, ctrl_busy});
        else n_pass++;
        n_total++;
        if (DB_OUT !== 16'h0 || sample_data !== 16'h0) $display("FAIL reset_data: got db=%h sd=%h want 0", DB_OUT, sample_data);
        else n_pass++;
        n_total++;
        if ({sample_valid, frame_done, cfg_done, timeout_err, sample_idx} !== 7'b0) $display("FAIL reset_pulses: got %b want 0", {sample_valid, frame_done, cfg_done, timeout_err, sample_idx});
        else n_pass++;
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_config();
        bit ok;
        clear_mon();
        pulse(1'b1, 1'b0);
        wait_idle(100, ok);
        @(negedge CLK);
        n_total++;
        if (!ok) $display("FAIL cfg_idle: got busy want idle within 100 cycles"); else n_pass++;
        n_total++;
        if (wr_falls !== 2) $display("FAIL cfg_wr_count: got %0d want 2", wr_falls); else n_pass++;
        n_total++;
        if (cfg_reg !== CFG_EXP) $display("FAIL cfg_reg: got %h want %h", cfg_reg, CFG_EXP); else n_pass++;
        n_total++;
        if (cd_cnt !== 1) $display("FAIL cfg_done_count: got %0d want 1", cd_cnt); else n_pass++;
        n_total++;
        if (busy_cyc !== CFG_CYC) $display("FAIL cfg_duration: got %0d want %0d", busy_cyc, CFG_CYC); else n_pass++;
        n_total++;
        if (DB_OE !== 1'b0 || CS_N !== 1'b1) $display("FAIL cfg_release: got oe=%b cs_n=%b want 0/1", DB_OE, CS_N); else n_pass++;
    endtask

    task automatic test_conversion();
        bit ok;
        int bad;
        clear_mon();
        pulse(1'b0, 1'b1);
        n_total++;
        if (CONVST !== 4'hF) $display("FAIL conv_start: got %h want F", CONVST); else n_pass++;
        wait_idle(1000, ok);
        @(negedge CLK);
        n_total++;
        if (!ok) $display("FAIL conv_idle: got busy want idle within 1000 cycles"); else n_pass++;
        n_total++;
        if (cv_cyc !== 2) $display("FAIL conv_width: got %0d want 2", cv_cyc); else n_pass++;
        n_total++;
        if (sq_idx.size() !== 8) $display("FAIL conv_count: got %0d want 8", sq_idx.size()); else n_pass++;
        for (int i = 0; i < 8 && i < sq_idx.size(); i++) begin
            n_total++;
            if (sq_idx[i] !== 3'(i) || sq_dat[i] !== ch[i])
                $display("FAIL conv_word%0d: got idx=%0d data=%h want idx=%0d data=%h", i, sq_idx[i], sq_dat[i], i, ch[i]);
            else n_pass++;
        end
        bad = fd_bad + ((fd_cnt != 1) ? 1 : 0);
        n_total++;
        if (bad !== 0) $display("FAIL conv_frame_done: got count=%0d misaligned=%0d want 1/0", fd_cnt, fd_bad); else n_pass++;
        n_total++;
        if (rd_falls !== 8) $display("FAIL conv_rd_strobes: got %0d want 8", rd_falls); else n_pass++;
    endtask

    task automatic test_random_frames();
        bit ok;
        int bad;
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(5, 0)) @(negedge CLK);
            clear_mon();
            pulse(1'b0, 1'b1);
            wait_idle(1000, ok);
            @(negedge CLK);
            bad = ok ? 0 : 1;
            if (sq_idx.size() != 8) bad++;
            for (int i = 0; i < 8 && i < sq_idx.size(); i++)
                if (sq_idx[i] !== 3'(i) || sq_dat[i] !== ch[i]) bad++;
            if (fd_cnt != 1 || fd_bad != 0) bad++;
            n_total++;
            if (bad !== 0) $display("FAIL rand_frame%0d: got %0d bad items (%0d samples) want 0", f, bad, sq_idx.size());
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int got;
        clear_mon();
        force_low = 1'b1;
        pulse(1'b0, 1'b1);
        got = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (timeout_err === 1'b1) begin got = k; break; end
        end
        n_total++;
        if (got !== TO_CYC) $display("FAIL timeout_cycle: got %0d want %0d", got, TO_CYC); else n_pass++;
        @(negedge CLK);
        n_total++;
        if (ctrl_busy !== 1'b0 || CS_N !== 1'b1) $display("FAIL timeout_idle: got busy=%b cs_n=%b want 0/1", ctrl_busy, CS_N); else n_pass++;
        n_total++;
        if (to_cnt !== 1 || sq_idx.size() !== 0 || rd_falls !== 0)
            $display("FAIL timeout_quiet: got pulses=%0d samples=%0d rd=%0d want 1/0/0", to_cnt, sq_idx.size(), rd_falls);
        else n_pass++;
        force_low = 1'b0;
        repeat (20) @(negedge CLK);
    endtask

    task automatic test_priority();
        bit ok;
        clear_mon();
        pulse(1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        pulse(1'b0, 1'b1);
        wait_idle(100, ok);
        repeat (20) @(negedge CLK);
        n_total++;
        if (!ok || cd_cnt !== 1 || wr_falls !== 2)
            $display("FAIL prio_config: got ok=%0d cfg_done=%0d wr=%0d want 1/1/2", ok, cd_cnt, wr_falls);
        else n_pass++;
        n_total++;
        if (cv_cyc !== 0 || sq_idx.size() !== 0)
            $display("FAIL prio_no_conv: got convst_cycles=%0d samples=%0d want 0/0", cv_cyc, sq_idx.size());
        else n_pass++;
        n_total++;
        if (busy_cyc !== CFG_CYC) $display("FAIL prio_duration: got %0d want %0d", busy_cyc, CFG_CYC); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        bit ok, found;
        int bad;
        clear_mon();
        pulse(1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (sq_idx.size() == 3 && RD_N === 1'b0) begin found = 1'b1; break; end
            @(negedge CLK);
        end
        n_total++;
        if (!found) $display("FAIL rst_reach_word3: got not reached want reached"); else n_pass++;
        RST_N = 1'b0;
        @(negedge CLK);
        n_total++;
        if (CS_N !== 1'b1 || RD_N !== 1'b1 || ctrl_busy !== 1'b0)
            $display("FAIL rst_abort: got cs_n=%b rd_n=%b busy=%b want 1/1/0", CS_N, RD_N, ctrl_busy);
        else n_pass++;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        n_total++;
        if (fd_cnt !== 0 || sq_idx.size() !== 3)
            $display("FAIL rst_no_partial: got frame_done=%0d samples=%0d want 0/3", fd_cnt, sq_idx.size());
        else n_pass++;
        clear_mon();
        pulse(1'b0, 1'b1);
        wait_idle(1000, ok);
        @(negedge CLK);
        bad = ok ? 0 : 1;
        if (sq_idx.size() != 8) bad++;
        for (int i = 0; i < 8 && i < sq_idx.size(); i++)
            if (sq_idx[i] !== 3'(i) || sq_dat[i] !== ch[i]) bad++;
        if (fd_cnt != 1 || rd_falls != 8) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL rst_fresh_frame: got %0d bad items (%0d samples) want 0", bad, sq_idx.size());
        else n_pass++;
    endtask

    task automatic test_invariants();
        n_total++;
        if (inv_bad !== 0) $display("FAIL invariants: got %0d violations want 0", inv_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_config();
        test_conversion();
        test_random_frames();
        test_timeout();
        test_priority();
        test_reset_mid_read();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
